mem_arbiter: RTL
================

# mem_arbiter

Shares the core's single-port synchronous memory between the instruction-fetch stage and the load/store stage. Grants at most one access per cycle. Load/store has fixed priority, with a starvation guard that forces a fetch grant after a bounded run of load/store wins. Read data returns one cycle after the grant, with a registered valid strobe routed to the requester that owns the read.

## Interface
- AW, 8: address width (word addresses)
- DW, 16: data width
- STARVE_MAX, 3: maximum consecutive load/store grants while fetch waits; must be ≥ 1
- clk  input  1  core clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous and active-low
- if_req  input  1  fetch read request; held until if_gnt
- if_addr  input  AW  fetch address
- if_gnt  output  1  fetch granted this cycle (combinational)
- if_rvalid  output  1  if_rdata valid (registered)
- if_rdata  output  DW  fetch read data (= mem_rdata)
- ls_req  input  1  load/store request; held until ls_gnt
- ls_we  input  1  1 = store, 0 = load
- ls_addr  input  AW  load/store address
- ls_wdata  input  DW  store data
- ls_gnt  output  1  load/store granted this cycle (combinational)
- ls_rvalid  output  1  ls_rdata valid, loads only (registered)
- ls_rdata  output  DW  load data (= mem_rdata)
- mem_en  output  1  memory access this cycle
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid the cycle after mem_en with mem_we = 0

## Operation
- State:
  - starve_cnt: counts 0..STARVE_MAX.
  - rd_owner: 2-bit one-hot register {if, ls} marking which requester owns the outstanding read.
- Grant selection each cycle:
  - Only ls_req: ls_gnt.
  - Only if_req: if_gnt.
  - Both, starve_cnt < STARVE_MAX: ls_gnt.
  - Both, starve_cnt == STARVE_MAX: if_gnt.
  - Neither: no grant.
- if_gnt and ls_gnt are never high together.
- starve_cnt update:
  - +1 when ls_gnt while if_req is high.
  - Cleared to 0 when if_gnt, or when if_req is low.
  - Saturates at STARVE_MAX.
- Memory drive:
  - When granted, mem_en = 1. mem_addr, mem_we and mem_wdata come from the winner.
  - Fetch: mem_we = 0.
  - No grant: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Read return:
  - rd_owner <= {if_gnt, ls_gnt & ~ls_we} each edge.
  - if_rvalid = rd_owner[if]; ls_rvalid = rd_owner[ls].
- Stores produce no rvalid.
- Back-to-back grants are allowed every cycle. A new grant may issue in the same cycle as the previous read's rvalid.
- rdata ports carry mem_rdata unconditionally. Data is meaningful only while the matching rvalid is high.

## Timing
- Grant latency: 0 cycles. A request sampled high with no competitor is granted in the same cycle.
- Read latency: rvalid is high exactly 1 cycle after the grant cycle, for 1 cycle.
- Store: the memory is written at the edge closing the grant cycle.
- Reset, while rst = 0:
  - starve_cnt = 0, rd_owner = 0.
  - if_rvalid = 0, ls_rvalid = 0.
  - if_gnt, ls_gnt, mem_en and mem_we forced to 0.
- Reset mid-read: an outstanding rvalid is dropped and never asserted after reset.
- Release: the first grant is possible in the first cycle with rst = 1.
- Request drop: a requester dropping req without a grant is legal. No state is retained for it except the starve_cnt clear.
- STARVE_MAX = 1: grants alternate ls, if, ls, if under continuous dual requests.

## Test plan
- Reset:
  - Stimulus: both reqs high throughout; rst pulsed low for 1 cycle, asserted in the middle of a fetch read.
  - Required: gnts = 0 and mem_en = 0 during reset. No if_rvalid after reset for the aborted read. ls_gnt in the first cycle after release.
- Lone fetch:
  - Stimulus: if_addr = 0x10, mem[0x10] = 0xBEEF.
  - Required: if_gnt in cycle N, if_rvalid = 1 in cycle N+1 with if_rdata = 0xBEEF, ls_rvalid = 0.
- Store then load:
  - Stimulus: ls_we = 1, addr 0x22, wdata 0x1234; then a load from 0x22.
  - Required: no rvalid for the store. ls_rvalid with ls_rdata = 0x1234 one cycle after the load grant.
- Starvation guard:
  - Stimulus: STARVE_MAX = 3, if_req and ls_req held high for 8 cycles.
  - Required grant sequence: ls, ls, ls, if, ls, ls, ls, if. Never two gnts in one cycle.
- Pipelined alternation:
  - Stimulus: loads and fetches granted on consecutive cycles.
  - Required: each rvalid goes to the correct owner one cycle after its grant, with the matching data.
- Idle bus:
  - Stimulus: no requests.
  - Required: mem_en = 0, mem_addr = 0, starve_cnt stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port synchronous memory between instruction fetch (if_*)
// and load/store (ls_*). At most one access is granted per cycle. Load/store
// wins by default; after STARVE_MAX consecutive load/store wins while fetch
// is waiting, fetch is forced through. Read data comes back one cycle after
// the grant, with a registered valid strobe for the requester that owns it.
//
// Ports:
//   clk, rst          core clock, asynchronous active-low reset
//   if_req/if_addr    fetch read request and address
//   if_gnt            fetch granted this cycle (combinational)
//   if_rvalid/rdata   fetch read return (valid registered, data = mem_rdata)
//   ls_req/we/addr/wdata  load/store request, 1 = store
//   ls_gnt            load/store granted this cycle (combinational)
//   ls_rvalid/rdata   load return (valid registered, data = mem_rdata)
//   mem_en/we/addr/wdata  memory command for this cycle
//   mem_rdata         memory read data, valid the cycle after a read
module mem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] StarveMax = CW'(STARVE_MAX);

  // Bit 1 = fetch owns the outstanding read, bit 0 = load owns it.
  localparam int OwnIf = 1;
  localparam int OwnLs = 0;

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic [1:0]    rd_owner_q, rd_owner_d;
  logic          starved;

  // Grants are gated by rst so nothing reaches the memory while reset is
  // held, even though the request inputs may still be active.
  always_comb begin
    starved = (starve_cnt_q == StarveMax);
    ls_gnt  = rst & ls_req & (~if_req | ~starved);
    if_gnt  = rst & if_req & (~ls_req | starved);
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ls_we;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end
  end

  // The counter only measures a run of load/store wins during which fetch
  // kept asking; any fetch grant or a gap in if_req restarts the run.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt || !if_req) begin
      starve_cnt_d = '0;
    end else if (ls_gnt && !starved) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
    rd_owner_d         = '0;
    rd_owner_d[OwnIf]  = if_gnt;
    rd_owner_d[OwnLs]  = ls_gnt & ~ls_we;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
      rd_owner_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign if_rvalid = rd_owner_q[OwnIf];
  assign ls_rvalid = rd_owner_q[OwnLs];
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

endmodule
